wb_unified_mem_arbiter: RTL and testbench
=========================================

Name: wb_unified_mem_arbiter

Overview:
- Shares one single-port unified memory Wishbone slave between the core's instruction-fetch master (iwb, read-only) and its data master (dwb, read/write).
- Sits between custom_riscv_core and the unified memory (32 KB, code plus data, tohost at word 1024).
- Keeps self-modifying code and FENCE.I coherent in both the SoC and the compliance benches.
- Grants one master per transaction, alternates on contention, routes ack/err/data back, and forces an error on a stalled slave.

Parameters:
- ADDR_W, 32, address width on all ports.
- TIMEOUT_CYCLES, 255, slave cycles allowed per transaction before a forced error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_adr_i  in  ADDR_W  instruction master address.
- i_cyc_i  in  1  instruction master cycle.
- i_stb_i  in  1  instruction master strobe.
- i_dat_o  out  32  fetch data.
- i_ack_o  out  1  fetch ack.
- i_err_o  out  1  fetch error.
- d_adr_i  in  ADDR_W  data master address.
- d_dat_i  in  32  data master write data.
- d_we_i  in  1  data master write enable.
- d_sel_i  in  4  data master byte selects.
- d_cyc_i  in  1  data master cycle.
- d_stb_i  in  1  data master strobe.
- d_dat_o  out  32  load data.
- d_ack_o  out  1  data ack.
- d_err_o  out  1  data error.
- m_adr_o  out  ADDR_W  slave address.
- m_dat_o  out  32  slave write data.
- m_we_o  out  1  slave write enable.
- m_sel_o  out  4  slave byte selects.
- m_cyc_o  out  1  slave cycle.
- m_stb_o  out  1  slave strobe.
- m_dat_i  in  32  slave read data.
- m_ack_i  in  1  slave ack.
- m_err_i  in  1  slave error.
- grant_o  out  2  01 = instruction master owns the slave, 10 = data master, 00 = none.
- timeout_o  out  1  one-cycle pulse when a forced timeout error is issued.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE, grant_o=00, last_grant=INSTR, counter=0.
  - All m_* outputs, acks, errs and timeout_o are 0; i_dat_o/d_dat_o are 0.
  - Applies immediately, including mid-transaction. A slave ack arriving during or after reset is ignored.
- States:
  - IDLE: no grant, m_cyc_o=m_stb_o=0.
  - GRANT_I, GRANT_D: one master owns the slave.
  - RECOVER: one dead cycle, m_cyc_o=0.
- IDLE transitions, evaluated on registered inputs at the clock edge:
  - Request = cyc&stb.
  - Only one master requesting → grant it.
  - Both requesting → grant the master that is not last_grant. After reset the data master wins first.
  - Grant takes effect the next cycle; minimum arbitration latency is 1 cycle.
- GRANT_x datapath:
  - m_adr_o, m_dat_o, m_we_o and m_sel_o are combinationally muxed from the granted master.
  - m_cyc_o and m_stb_o follow the granted master's cyc and stb.
  - Instruction grant forces m_we_o=0, m_sel_o=4'hF, m_dat_o=0.
- GRANT_x response path:
  - m_ack_i, m_err_i and m_dat_i route combinationally to the granted master only, with zero added latency. The non-granted master's ack/err stay 0 and its dat output is 0.
- GRANT_x exits:
  - On m_ack_i or m_err_i: last_grant is updated, then RECOVER.
  - If the granted master drops cyc before ack (abort): go to IDLE with no ack delivered; a late slave ack is ignored.
- RECOVER lasts exactly 1 cycle, then IDLE. This guarantees m_stb_o falls between transactions, so slaves that gate on !ack re-arm.
- Back-to-back throughput is therefore 1 grant cycle + slave latency + 1 recover cycle + 1 arbitration cycle.
- Timeout:
  - Counter clears on grant and increments each GRANT cycle without ack or err.
  - When it reaches TIMEOUT_CYCLES (if nonzero), the arbiter asserts the granted master's err_o and timeout_o for 1 cycle, deasserts m_cyc_o/m_stb_o that same cycle, and goes to RECOVER.
  - A slave ack in the same cycle as the timeout wins: ack is delivered, no error.
- Simultaneous m_ack_i and m_err_i: both are forwarded; the master treats err as dominant.
- A request that arrives while the other master owns the slave is held by that master (Wishbone stall) and is served after RECOVER.
- grant_o is registered and equals the state encoding.

Test Plan:
- Single fetch: i_cyc/stb=1, adr=0x0, slave acks 1 cycle after stb with 0x00000013 → grant_o=01 one cycle after request; i_ack_o=1 with i_dat_o=0x00000013; d_ack_o=0; m_we_o=0, m_sel_o=F.
- Contention after reset: both request in the same cycle → data is served first (grant_o=10), then RECOVER, then instruction (01). Repeat with both held → grants alternate 10,01,10,01.
- Masked store to tohost: d_we=1, adr=0x1000, sel=0001, dat=0x1 → m_* mirror d_* exactly; d_ack_o pulses once; the slave sees m_stb_o low for ≥1 cycle before the next grant.
- Timeout: TIMEOUT_CYCLES=4, slave never acks on a fetch → i_err_o and timeout_o pulse 4 cycles after grant, m_cyc_o drops; a subsequent data request is granted normally.
- Abort and reset: data master drops cyc mid-wait → IDLE, a late m_ack_i produces no d_ack_o. Assert rst mid-transaction → all outputs 0 asynchronously; after release the first contended grant goes to the data master.

Source files
------------

// File: rtl/wb_unified_mem_arbiter.sv
// Two-master Wishbone arbiter: instruction fetch and data share one memory slave.
// Alternating grant on contention, one recover cycle per transaction, stall timeout.
module wb_unified_mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_adr_i,
   input  logic              i_cyc_i,
   input  logic              i_stb_i,
   output logic [31:0]       i_dat_o,
   output logic              i_ack_o,
   output logic              i_err_o,
   input  logic [ADDR_W-1:0] d_adr_i,
   input  logic [31:0]       d_dat_i,
   input  logic              d_we_i,
   input  logic [3:0]        d_sel_i,
   input  logic              d_cyc_i,
   input  logic              d_stb_i,
   output logic [31:0]       d_dat_o,
   output logic              d_ack_o,
   output logic              d_err_o,
   output logic [ADDR_W-1:0] m_adr_o,
   output logic [31:0]       m_dat_o,
   output logic              m_we_o,
   output logic [3:0]        m_sel_o,
   output logic              m_cyc_o,
   output logic              m_stb_o,
   input  logic [31:0]       m_dat_i,
   input  logic              m_ack_i,
   input  logic              m_err_i,
   output logic [1:0]        grant_o,
   output logic              timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_GNT_I = 2'b01,
      S_GNT_D = 2'b10,
      S_REC   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] LP_TO = CNT_W'(TIMEOUT_CYCLES);

   state_t           r_state;
   state_t           w_next;
   logic             r_last_d;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_grant;

   logic w_i_req;
   logic w_d_req;
   logic w_resp;
   logic w_in_grant;
   logic w_own_cyc;
   logic w_cnt_hit;
   logic w_to;

   assign w_i_req    = i_cyc_i & i_stb_i;
   assign w_d_req    = d_cyc_i & d_stb_i;
   assign w_resp     = m_ack_i | m_err_i;
   assign w_in_grant = (r_state == S_GNT_I) || (r_state == S_GNT_D);
   assign w_own_cyc  = (r_state == S_GNT_I) ? i_cyc_i :
                       (r_state == S_GNT_D) ? d_cyc_i : 1'b0;
   assign w_cnt_hit  = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_TO);
   // A real slave response in the timeout cycle takes precedence
   assign w_to       = w_in_grant & w_own_cyc & w_cnt_hit & ~w_resp;
   assign grant_o    = r_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_grant  <= 2'b00;
         r_last_d <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         r_grant <= (w_next == S_GNT_I) ? 2'b01 :
                    (w_next == S_GNT_D) ? 2'b10 : 2'b00;
         if (w_in_grant && w_own_cyc && (w_resp || w_to))
            r_last_d <= (r_state == S_GNT_D);
         if (!w_in_grant)
            r_cnt <= '0;
         else if (!w_resp)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_d_req && (!w_i_req || !r_last_d))
               w_next = S_GNT_D;
            else if (w_i_req)
               w_next = S_GNT_I;
         end
         S_GNT_I, S_GNT_D: begin
            if (!w_own_cyc)
               w_next = S_IDLE;
            else if (w_resp || w_to)
               w_next = S_REC;
         end
         S_REC:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      m_adr_o   = '0;
      m_dat_o   = '0;
      m_we_o    = 1'b0;
      m_sel_o   = 4'h0;
      m_cyc_o   = 1'b0;
      m_stb_o   = 1'b0;
      i_dat_o   = '0;
      i_ack_o   = 1'b0;
      i_err_o   = 1'b0;
      d_dat_o   = '0;
      d_ack_o   = 1'b0;
      d_err_o   = 1'b0;
      timeout_o = 1'b0;
      case (r_state)
         S_GNT_I: begin
            m_adr_o   = i_adr_i;
            m_sel_o   = 4'hF;
            m_cyc_o   = i_cyc_i & ~w_to;
            m_stb_o   = i_stb_i & ~w_to;
            i_dat_o   = m_dat_i;
            i_ack_o   = m_ack_i & i_cyc_i;
            i_err_o   = (m_err_i & i_cyc_i) | w_to;
            timeout_o = w_to;
         end
         S_GNT_D: begin
            m_adr_o   = d_adr_i;
            m_dat_o   = d_dat_i;
            m_we_o    = d_we_i;
            m_sel_o   = d_sel_i;
            m_cyc_o   = d_cyc_i & ~w_to;
            m_stb_o   = d_stb_i & ~w_to;
            d_dat_o   = m_dat_i;
            d_ack_o   = m_ack_i & d_cyc_i;
            d_err_o   = (m_err_i & d_cyc_i) | w_to;
            timeout_o = w_to;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench for wb_unified_mem_arbiter with a 4-cycle timeout.
// Each task drives one scenario and checks hand-computed values inline.
module tb_wb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_adr_i;
   logic        i_cyc_i, i_stb_i;
   logic [31:0] i_dat_o;
   logic        i_ack_o, i_err_o;
   logic [31:0] d_adr_i, d_dat_i;
   logic        d_we_i;
   logic [3:0]  d_sel_i;
   logic        d_cyc_i, d_stb_i;
   logic [31:0] d_dat_o;
   logic        d_ack_o, d_err_o;
   logic [31:0] m_adr_o, m_dat_o;
   logic        m_we_o;
   logic [3:0]  m_sel_o;
   logic        m_cyc_o, m_stb_o;
   logic [31:0] m_dat_i;
   logic        m_ack_i, m_err_i;
   logic [1:0]  grant_o;
   logic        timeout_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_unified_mem_arbiter #(
      .ADDR_W(32), .TIMEOUT_CYCLES(4), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
      .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
      .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i),
      .d_sel_i(d_sel_i), .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
      .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o),
      .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
      .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      i_adr_i = '0; i_cyc_i = 0; i_stb_i = 0;
      d_adr_i = '0; d_dat_i = '0; d_we_i = 0; d_sel_i = 4'h0;
      d_cyc_i = 0; d_stb_i = 0;
      m_dat_i = '0; m_ack_i = 0; m_err_i = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [103:0] v;
      v = {grant_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o,
           i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o,
           i_dat_o, d_dat_o[31:7]};
      total++;
      if (v !== '0 || d_dat_o !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", v);
      end
   endtask

   task automatic test_single_fetch();
      i_adr_i = 32'h0; i_cyc_i = 1; i_stb_i = 1;
      #1;
      total++;
      if (grant_o !== 2'b00) begin
         bad++; $display("FAIL fetch_pre_grant got=%b exp=00", grant_o);
      end
      tick();
      total++;
      if ({grant_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_dat_o} !==
          {2'b01, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0}) begin
         bad++;
         $display("FAIL fetch_grant got=%b/%b/%b/%b/%h/%h exp=01/1/1/0/f/0",
                  grant_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_dat_o);
      end
      tick();
      m_dat_i = 32'h0000_0013; m_ack_i = 1;
      #1;
      total++;
      if ({i_ack_o, i_dat_o, d_ack_o, d_dat_o} !==
          {1'b1, 32'h13, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL fetch_ack got=%b/%h/%b/%h exp=1/13/0/0",
                  i_ack_o, i_dat_o, d_ack_o, d_dat_o);
      end
      tick();
      m_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
      #1;
      total++;
      if ({grant_o, m_stb_o, i_ack_o} !== 4'b0000) begin
         bad++;
         $display("FAIL fetch_recover got=%b/%b/%b exp=00/0/0",
                  grant_o, m_stb_o, i_ack_o);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [1:0] exp_g, exp_ack;
      logic [31:0] exp_adr;
      do_reset();
      i_adr_i = 32'h40; i_cyc_i = 1; i_stb_i = 1;
      d_adr_i = 32'h2000; d_sel_i = 4'hF; d_cyc_i = 1; d_stb_i = 1;
      for (int k = 0; k < 4; k++) begin
         exp_g   = (k % 2 == 0) ? 2'b10 : 2'b01;
         exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_adr = (k % 2 == 0) ? 32'h2000 : 32'h40;
         tick();
         total++;
         if (grant_o !== exp_g || m_adr_o !== exp_adr) begin
            bad++;
            $display("FAIL contend_grant%0d got=%b/%h exp=%b/%h",
                     k, grant_o, m_adr_o, exp_g, exp_adr);
         end
         m_dat_i = 32'h100 + k; m_ack_i = 1;
         #1;
         total++;
         if ({i_ack_o, d_ack_o} !== exp_ack) begin
            bad++;
            $display("FAIL contend_ack%0d got=%b exp=%b",
                     k, {i_ack_o, d_ack_o}, exp_ack);
         end
         tick();
         m_ack_i = 0;
         #1;
         total++;
         if ({grant_o, m_cyc_o, m_stb_o} !== 4'b0000) begin
            bad++;
            $display("FAIL contend_recover%0d got=%b/%b/%b exp=00/0/0",
                     k, grant_o, m_cyc_o, m_stb_o);
         end
         tick();
         total++;
         if (grant_o !== 2'b00) begin
            bad++;
            $display("FAIL contend_idle%0d got=%b exp=00", k, grant_o);
         end
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_masked_store();
      d_adr_i = 32'h1000; d_dat_i = 32'h1; d_we_i = 1; d_sel_i = 4'b0001;
      d_cyc_i = 1; d_stb_i = 1;
      tick();
      #1;
      total++;
      if ({m_adr_o, m_dat_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o} !==
          {32'h1000, 32'h1, 1'b1, 4'b0001, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL store_mirror got=%h/%h/%b/%b/%b/%b",
                  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o);
      end
      m_ack_i = 1;
      #1;
      total++;
      if ({d_ack_o, i_ack_o} !== 2'b10) begin
         bad++;
         $display("FAIL store_ack got=%b exp=10", {d_ack_o, i_ack_o});
      end
      tick();
      m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0; d_sel_i = 4'h0;
      i_adr_i = 32'h80; i_cyc_i = 1; i_stb_i = 1;
      #1;
      total++;
      if ({d_ack_o, m_stb_o, grant_o} !== 4'b0000) begin
         bad++;
         $display("FAIL store_pulse got=%b/%b/%b exp=0/0/00",
                  d_ack_o, m_stb_o, grant_o);
      end
      tick();
      total++;
      if ({m_stb_o, grant_o} !== 3'b000) begin
         bad++;
         $display("FAIL store_gap got=%b/%b exp=0/00", m_stb_o, grant_o);
      end
      tick();
      total++;
      if (grant_o !== 2'b01 || m_adr_o !== 32'h80) begin
         bad++;
         $display("FAIL store_next got=%b/%h exp=01/80", grant_o, m_adr_o);
      end
      m_ack_i = 1;
      tick();
      m_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
      tick();
   endtask

   task automatic test_timeout();
      i_adr_i = 32'h100; i_cyc_i = 1; i_stb_i = 1;
      tick();
      total++;
      if (grant_o !== 2'b01) begin
         bad++; $display("FAIL to_grant got=%b exp=01", grant_o);
      end
      for (int j = 1; j < 4; j++) begin
         tick();
         total++;
         if ({i_err_o, timeout_o, m_cyc_o} !== 3'b001) begin
            bad++;
            $display("FAIL to_wait%0d got=%b exp=001",
                     j, {i_err_o, timeout_o, m_cyc_o});
         end
      end
      tick();
      total++;
      if ({i_err_o, timeout_o, m_cyc_o, m_stb_o, d_err_o} !== 5'b11000) begin
         bad++;
         $display("FAIL to_fire got=%b exp=11000",
                  {i_err_o, timeout_o, m_cyc_o, m_stb_o, d_err_o});
      end
      tick();
      i_cyc_i = 0; i_stb_i = 0;
      d_adr_i = 32'h200; d_sel_i = 4'hF; d_cyc_i = 1; d_stb_i = 1;
      #1;
      total++;
      if ({timeout_o, i_err_o, grant_o} !== 4'b0000) begin
         bad++;
         $display("FAIL to_pulse got=%b/%b/%b exp=0/0/00",
                  timeout_o, i_err_o, grant_o);
      end
      tick();
      tick();
      total++;
      if (grant_o !== 2'b10 || m_adr_o !== 32'h200) begin
         bad++;
         $display("FAIL to_after got=%b/%h exp=10/200", grant_o, m_adr_o);
      end
      m_ack_i = 1;
      tick();
      m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0;
      tick();
   endtask

   task automatic test_ack_beats_timeout();
      i_adr_i = 32'h104; i_cyc_i = 1; i_stb_i = 1;
      tick();
      repeat (4) tick();
      m_ack_i = 1; m_dat_i = 32'hDEAD;
      #1;
      total++;
      if ({i_ack_o, i_err_o, timeout_o, m_cyc_o} !== 4'b1001 ||
          i_dat_o !== 32'hDEAD) begin
         bad++;
         $display("FAIL ack_wins got=%b/%h exp=1001/dead",
                  {i_ack_o, i_err_o, timeout_o, m_cyc_o}, i_dat_o);
      end
      tick();
      m_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
      #1;
      total++;
      if (grant_o !== 2'b00) begin
         bad++; $display("FAIL ack_wins_rec got=%b exp=00", grant_o);
      end
      tick();
   endtask

   task automatic test_abort();
      d_adr_i = 32'h300; d_sel_i = 4'hF; d_cyc_i = 1; d_stb_i = 1;
      tick();
      total++;
      if (grant_o !== 2'b10) begin
         bad++; $display("FAIL abort_grant got=%b exp=10", grant_o);
      end
      tick();
      d_cyc_i = 0; d_stb_i = 0;
      #1;
      total++;
      if (m_cyc_o !== 1'b0) begin
         bad++; $display("FAIL abort_cyc got=%b exp=0", m_cyc_o);
      end
      tick();
      total++;
      if (grant_o !== 2'b00) begin
         bad++; $display("FAIL abort_idle got=%b exp=00", grant_o);
      end
      m_ack_i = 1; m_dat_i = 32'h55;
      #1;
      total++;
      if ({d_ack_o, d_err_o, i_ack_o} !== 3'b000 || d_dat_o !== 32'h0) begin
         bad++;
         $display("FAIL abort_late_ack got=%b/%h exp=000/0",
                  {d_ack_o, d_err_o, i_ack_o}, d_dat_o);
      end
      tick();
      m_ack_i = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      d_adr_i = 32'h400; d_sel_i = 4'hF; d_cyc_i = 1; d_stb_i = 1;
      tick();
      m_ack_i = 1;
      tick();
      m_ack_i = 0;
      tick();
      tick();
      total++;
      if (grant_o !== 2'b10) begin
         bad++; $display("FAIL rmid_grant got=%b exp=10", grant_o);
      end
      rst = 1; m_ack_i = 1; m_dat_i = 32'h77;
      #1;
      total++;
      if ({grant_o, m_cyc_o, m_stb_o, d_ack_o, m_adr_o, d_dat_o} !== '0) begin
         bad++;
         $display("FAIL rmid_async got=%b/%b/%b/%b/%h/%h exp=0",
                  grant_o, m_cyc_o, m_stb_o, d_ack_o, m_adr_o, d_dat_o);
      end
      tick();
      total++;
      if ({grant_o, m_cyc_o, d_ack_o, d_dat_o} !== '0) begin
         bad++;
         $display("FAIL rmid_held got=%b/%b/%b/%h exp=0",
                  grant_o, m_cyc_o, d_ack_o, d_dat_o);
      end
      m_ack_i = 0;
      i_adr_i = 32'h500; i_cyc_i = 1; i_stb_i = 1;
      rst = 0;
      tick();
      total++;
      if (grant_o !== 2'b10 || m_adr_o !== 32'h400) begin
         bad++;
         $display("FAIL rmid_first got=%b/%h exp=10/400", grant_o, m_adr_o);
      end
      m_ack_i = 1;
      tick();
      m_ack_i = 0;
      clear_inputs();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #2;
      test_reset();
      rst = 1'b0;
      tick();
      test_single_fetch();
      test_contention();
      test_masked_store();
      test_timeout();
      test_ack_beats_timeout();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
